// File: rtl/label_pkg.sv
// label_pkg: shared definitions for the label-stream bounding-box tracker.
//   - label_e       : per-pixel class codes produced by the segmentation stage
//   - H_ACT / V_ACT : active label raster (QVGA)
//   - NO_BOX_COORD  : off-screen coordinate published while no box is live
//   - state_t       : tracker FSM encoding, kept as plain constants so the
//                     state register stays a simple 2-bit vector
package label_pkg;

  typedef enum logic [2:0] {
    ROAD       = 3'd0,
    WALKROAD   = 3'd1,
    BACKGROUND = 3'd2,
    CAR        = 3'd3,
    HUMAN      = 3'd4
  } label_e;

  localparam int H_ACT = 320;
  localparam int V_ACT = 240;

  // 400 sits past the right/bottom edge and still leaves room for the
  // downstream +/-20 marker offset without wrapping a 10-bit coordinate.
  localparam logic [9:0] NO_BOX_COORD = 10'd400;

  // Running min starts at the largest code so any real pixel replaces it.
  localparam logic [9:0]  COORD_MIN_INIT = 10'h3FF;
  localparam logic [9:0]  COORD_MAX_INIT = 10'd0;
  localparam logic [16:0] COUNT_SAT      = 17'h1FFFF;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCUM  = 2'd1;
  localparam state_t ST_COMMIT = 2'd2;

endpackage

// File: rtl/label_bbox_tracker_accum.sv
// bbox_accum: running bounding box and pixel count for the frame in flight.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   init             reload min/max/count to their empty values this edge
//   add_pix          fold pix_x/pix_y into the box and bump the count
//   pix_x, pix_y     coordinates of the current pixel
//   rxmin..rymax     running box
//   rcnt             running qualified-pixel count (saturating)
// When init and add_pix coincide, the pixel merges with the empty values,
// so it becomes the first pixel of the new frame.
module bbox_accum
  import label_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init,
  input  logic        add_pix,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [9:0]  rxmin,
  output logic [9:0]  rymin,
  output logic [9:0]  rxmax,
  output logic [9:0]  rymax,
  output logic [16:0] rcnt
);

  logic [9:0]  base_xmin, base_ymin, base_xmax, base_ymax;
  logic [16:0] base_cnt;
  logic [9:0]  nxt_xmin, nxt_ymin, nxt_xmax, nxt_ymax;
  logic [16:0] nxt_cnt;

  always_comb begin
    base_xmin = init ? COORD_MIN_INIT : rxmin;
    base_ymin = init ? COORD_MIN_INIT : rymin;
    base_xmax = init ? COORD_MAX_INIT : rxmax;
    base_ymax = init ? COORD_MAX_INIT : rymax;
    base_cnt  = init ? '0 : rcnt;

    // NOTE: every output of this block gets a value before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    nxt_xmin = base_xmin;
    nxt_ymin = base_ymin;
    nxt_xmax = base_xmax;
    nxt_ymax = base_ymax;
    nxt_cnt  = base_cnt;

    if (add_pix) begin
      nxt_xmin = (pix_x < base_xmin) ? pix_x : base_xmin;
      nxt_ymin = (pix_y < base_ymin) ? pix_y : base_ymin;
      nxt_xmax = (pix_x > base_xmax) ? pix_x : base_xmax;
      nxt_ymax = (pix_y > base_ymax) ? pix_y : base_ymax;
      nxt_cnt  = (base_cnt == COUNT_SAT) ? base_cnt : base_cnt + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxmin <= COORD_MIN_INIT;
      rymin <= COORD_MIN_INIT;
      rxmax <= COORD_MAX_INIT;
      rymax <= COORD_MAX_INIT;
      rcnt  <= '0;
    end else begin
      rxmin <= nxt_xmin;
      rymin <= nxt_ymin;
      rxmax <= nxt_xmax;
      rymax <= nxt_ymax;
      rcnt  <= nxt_cnt;
    end
  end

endmodule

// File: rtl/label_bbox_tracker.sv
// label_bbox_tracker: watches the per-pixel label stream and publishes one
// bounding box per frame for the target class. The box is updated only in
// the single COMMIT cycle after frame_end, so it stays stable for the whole
// following display frame.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   frame_start            pulse before the first pixel of a frame
//   frame_end              pulse on or after the last pixel of a frame
//   pix_valid              pix_x/pix_y/pix_label valid this cycle
//   pix_x, pix_y           pixel column / row
//   pix_label              pixel class
//   x_min..y_max           committed box (NO_BOX_COORD when none)
//   box_valid              committed box is live
//   pix_count              target pixel count of the last completed frame
//   frame_done             one-cycle pulse when the outputs update
module label_bbox_tracker
  import label_pkg::state_t, label_pkg::ST_IDLE, label_pkg::ST_ACCUM,
         label_pkg::ST_COMMIT, label_pkg::NO_BOX_COORD;
#(
  parameter int         H_ACT        = label_pkg::H_ACT,
  parameter int         V_ACT        = label_pkg::V_ACT,
  parameter logic [2:0] TARGET_LABEL = label_pkg::CAR,
  parameter int         MIN_COUNT    = 64,
  parameter int         HOLD_FRAMES  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic        pix_valid,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [2:0]  pix_label,
  output logic [9:0]  x_min,
  output logic [9:0]  y_min,
  output logic [9:0]  x_max,
  output logic [9:0]  y_max,
  output logic        box_valid,
  output logic [16:0] pix_count,
  output logic        frame_done
);

  localparam int                MISS_W   = $clog2(HOLD_FRAMES + 1);
  localparam logic [MISS_W-1:0] MISS_SAT = MISS_W'(HOLD_FRAMES);
  localparam logic [9:0]        X_LIM    = 10'(H_ACT);
  localparam logic [9:0]        Y_LIM    = 10'(V_ACT);
  localparam logic [16:0]       CNT_MIN  = 17'(MIN_COUNT);

  state_t            state, state_nxt;
  logic              qualify, add_pix, commit_hit;
  logic [MISS_W-1:0] miss, miss_inc;
  logic [9:0]        rxmin, rymin, rxmax, rymax;
  logic [16:0]       rcnt;

  assign qualify = pix_valid && (pix_label == TARGET_LABEL) &&
                   (pix_x < X_LIM) && (pix_y < Y_LIM);

  // A pixel arriving with frame_start during COMMIT belongs to the new frame;
  // IDLE drops everything.
  assign add_pix = qualify &&
                   ((state == ST_ACCUM) || ((state == ST_COMMIT) && frame_start));

  bbox_accum u_accum (
    .clk     (clk),
    .reset_n (reset_n),
    .init    (frame_start),
    .add_pix (add_pix),
    .pix_x   (pix_x),
    .pix_y   (pix_y),
    .rxmin   (rxmin),
    .rymin   (rymin),
    .rxmax   (rxmax),
    .rymax   (rymax),
    .rcnt    (rcnt)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (frame_start) state_nxt = ST_ACCUM;
      // frame_start wins over a simultaneous frame_end: the frame restarts
      // and nothing is committed.
      ST_ACCUM:  if (frame_end && !frame_start) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = frame_start ? ST_ACCUM : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign commit_hit = (rcnt >= CNT_MIN);
  assign miss_inc   = (miss == MISS_SAT) ? miss : miss + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      miss       <= '0;
      x_min      <= NO_BOX_COORD;
      y_min      <= NO_BOX_COORD;
      x_max      <= NO_BOX_COORD;
      y_max      <= NO_BOX_COORD;
      box_valid  <= 1'b0;
      pix_count  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= (state == ST_COMMIT);
      if (state == ST_COMMIT) begin
        pix_count <= rcnt;
        if (commit_hit) begin
          x_min     <= rxmin;
          y_min     <= rymin;
          x_max     <= rxmax;
          y_max     <= rymax;
          box_valid <= 1'b1;
          miss      <= '0;
        end else begin
          miss <= miss_inc;
          // Earlier misses keep the previous box on screen.
          if (miss_inc == MISS_SAT) begin
            x_min     <= NO_BOX_COORD;
            y_min     <= NO_BOX_COORD;
            x_max     <= NO_BOX_COORD;
            y_max     <= NO_BOX_COORD;
            box_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule
